icache_dm: RTL

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/icache_dm.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with one outstanding line refill.
// Hits answer one cycle after acceptance; misses refill a whole line in ascending word order.
module icache_dm #(
  parameter int unsigned LINES    = 64,
  parameter int unsigned WORDS    = 4,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  output logic        resp_error,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_DATA, RESP} state_t;

  state_t             state, state_nx;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags [LINES];
  logic [31:0]        data [LINES*WORDS];
  logic               flush_pend;
  logic [OFF_W-1:0]   beat;
  logic [OFF_W-1:0]   lat_word;
  logic [31:0]        word_cap;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [OFF_W-1:0]   req_word;
  logic [31:0]        req_off;
  logic               req_err;
  logic               hit;
  logic               accept;
  logic               miss_start;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               beat_in;
  logic               last_beat;
  logic               clear_all;

  assign req_idx  = req_addr[2+OFF_W +: IDX_W];
  assign req_tag  = req_addr[31 -: TAG_W];
  assign req_word = req_addr[2 +: OFF_W];
  assign req_off  = req_addr - MEM_BASE;
  assign req_err  = (req_addr[1:0] != 2'b00) || (req_addr < MEM_BASE) || (req_off >= MEM_SIZE);
  assign hit      = valid[req_idx] && (tags[req_idx] == req_tag);

  assign accept     = req_valid && req_ready;
  assign miss_start = accept && !req_err && !hit;

  // The latched refill address doubles as the fill tag/index source.
  assign fill_idx  = mem_req_addr[2+OFF_W +: IDX_W];
  assign fill_tag  = mem_req_addr[31 -: TAG_W];
  assign beat_in   = (state == MISS_DATA) && mem_resp_valid;
  assign last_beat = beat_in && (beat == OFF_W'(WORDS - 1));

  // A flush seen during a refill is honoured as the FSM leaves RESP.
  assign clear_all = ((state == IDLE) || (state == RESP)) && (flush || flush_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !flush && !flush_pend;
        if (req_valid && !flush && !flush_pend && !req_err && !hit)
          state_nx = MISS_REQ;
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nx = MISS_DATA;
      end
      MISS_DATA: if (last_beat) state_nx = RESP;
      RESP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
    end else if (clear_all) begin
      flush_pend <= 1'b0;
    end else if (flush && (state != IDLE)) begin
      flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (miss_start) begin
      valid[req_idx] <= 1'b0;
    end else if (last_beat) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_in)   data[{fill_idx, beat}] <= mem_resp_data;
    if (last_beat) tags[fill_idx]         <= fill_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat         <= '0;
      lat_word     <= '0;
      word_cap     <= '0;
      mem_req_addr <= '0;
      resp_valid   <= 1'b0;
      resp_inst    <= '0;
      resp_error   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        if (req_err) begin
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
          resp_inst  <= '0;
        end else if (hit) begin
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_inst  <= data[{req_idx, req_word}];
        end else begin
          mem_req_addr <= {req_addr[31:2+OFF_W], {(2+OFF_W){1'b0}}};
          lat_word     <= req_word;
          beat         <= '0;
        end
      end
      if (beat_in) begin
        beat <= beat + 1'b1;
        if (beat == lat_word) word_cap <= mem_resp_data;
        // The requested word may arrive on the final beat itself.
        if (last_beat) begin
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_inst  <= (beat == lat_word) ? mem_resp_data : word_cap;
        end
      end
    end
  end

endmodule
